// File: rtl/first_counter_if.sv
// Count-enable and counter status bundle between a counter and its user.
// The counter side takes the slave modport; the controlling side takes master.
interface first_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [WIDTH-1:0] counter_out;
  logic             tc;
  logic             overflow;

  modport master (
    output enable,
    input  counter_out,
    input  tc,
    input  overflow
  );

  modport slave (
    input  enable,
    output counter_out,
    output tc,
    output overflow
  );
endinterface

// File: rtl/first_counter.sv
// Wrapping up-counter with sticky overflow and combinational terminal count; 1-cycle latency.
// No backpressure: advances on every clock where enable is sampled high.
module first_counter #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  first_counter_if.slave  cnt_if
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH:0]   sum;

  // Extra MSB of sum carries the wrap indication; it never reaches the count.
  assign sum = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (!reset) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (cnt_if.enable) begin
      count_d = sum[WIDTH-1:0];
      if (sum[WIDTH]) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    ovf_q   <= ovf_d;
  end

  assign cnt_if.counter_out = count_q;
  assign cnt_if.overflow    = ovf_q;
  assign cnt_if.tc          = cnt_if.enable & (&count_q);

endmodule

// File: tb/tb_first_counter.sv
// Randomised and directed checks of first_counter against an arithmetic reference model.
module tb_first_counter;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk;
  logic reset;

  first_counter_if #(.WIDTH(WIDTH)) cnt_if ();

  first_counter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .cnt_if (cnt_if.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int m_cnt    = 0;
  bit m_ovf    = 1'b0;
  bit m_valid  = 1'b0;
  int tc_seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs on the falling edge, check tc, then check registered outputs.
  task automatic step(input logic en, input logic rst_n);
    @(negedge clk);
    cnt_if.enable = en;
    reset         = rst_n;
    #1;
    if (m_valid) begin
      check_val("tc", {31'd0, cnt_if.tc}, {31'd0, (m_cnt == MAXV) && en});
      if (cnt_if.tc === 1'b1) tc_seen++;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (en) begin
      if (m_cnt == MAXV) m_ovf = 1'b1;
      m_cnt = (m_cnt + 1) % (MAXV + 1);
    end
    #1;
    if (m_valid) begin
      check_val("counter_out", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, m_cnt);
      check_val("overflow", {31'd0, cnt_if.overflow}, {31'd0, m_ovf});
    end
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    cnt_if.enable = 1'b0;

    // Reset state
    step(1'b0, 1'b0);
    check_val("rst_cnt", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 0);
    check_val("rst_ovf", {31'd0, cnt_if.overflow}, 0);
    check_val("rst_tc", {31'd0, cnt_if.tc}, 0);

    // Count to 10 then hold
    run(10, 1'b1);
    check_val("count10", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 10);
    run(3, 1'b0);
    check_val("count10_hold", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 10);

    // Wrap: 17 enabled cycles from 0
    step(1'b0, 1'b0);
    tc_seen = 0;
    run(17, 1'b1);
    check_val("wrap_end", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 1);
    check_val("wrap_ovf", {31'd0, cnt_if.overflow}, 1);
    check_val("wrap_tc_once", tc_seen, 1);

    // Reset priority at count 7 with enable high
    step(1'b0, 1'b0);
    run(7, 1'b1);
    check_val("pri_at7", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 7);
    step(1'b1, 1'b0);
    check_val("pri_cnt", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 0);
    check_val("pri_ovf", {31'd0, cnt_if.overflow}, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1);
      check_val("pri_resume", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, k);
    end

    // Random enable/reset
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) != 0));
    end

    // Hold at 5 for 20 cycles
    step(1'b0, 1'b0);
    run(5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      check_val("hold5", {{(32-WIDTH){1'b0}}, cnt_if.counter_out}, 5);
      check_val("hold_tc", {31'd0, cnt_if.tc}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
